urna_entrada: RTL and testbench

URNA_ENTRADA -- requirements
Module: urna_entrada

---
 rtl/urna_entrada.sv | 153 +++++++++++++++
 tb/tb_urna_entrada.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/urna_entrada.sv
// rtl/urna_entrada.sv - vote-digit entry: key synchronizers, debouncers and the entry FSM
// Confirm/finish keys are debounced into single press events that drive a 4-digit collector.

module urna_entrada_debounce #(
    parameter int DEB_COUNT = 500000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key_n,
    output logic press
);

    localparam logic [19:0] DEB_LAST = 20'(DEB_COUNT - 1);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic        level_d;
    logic        armed;
    logic [1:0]  age;
    logic [19:0] count;

    // A key only becomes eligible once it has been seen released after reset,
    // so a key held through reset cannot fire when the chain refills with real samples.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            armed   <= 1'b0;
            age     <= 2'd0;
            count   <= 20'd0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            level_d <= level;
            if (age != 2'd2)
                age <= age + 2'd1;
            if (age == 2'd2 && sync2)
                armed <= 1'b1;
            if (sync2 == level) begin
                count <= 20'd0;
            end else if (count == DEB_LAST) begin
                count <= 20'd0;
                level <= sync2;
            end else begin
                count <= count + 20'd1;
            end
        end
    end

    assign press = armed & level_d & ~level;

endmodule

module urna_entrada #(
    parameter int DEB_COUNT = 500000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] SwDigit,
    input  logic       KeyConfirm_n,
    input  logic       KeyFinish_n,
    output logic [3:0] Digit,
    output logic       Valid,
    output logic       Finish,
    output logic [2:0] Count,
    output logic       Locked,
    output logic       Invalid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] sw_sync1;
    logic [3:0] sw_sync2;
    logic [3:0] digit_next;
    logic [2:0] count_next;
    logic       valid_next;
    logic       finish_next;
    logic       invalid_next;
    logic       confirm_ev;
    logic       finish_ev;

    urna_entrada_debounce #(.DEB_COUNT(DEB_COUNT)) u_confirm (
        .Clock (Clock),
        .Reset (Reset),
        .key_n (KeyConfirm_n),
        .press (confirm_ev)
    );

    urna_entrada_debounce #(.DEB_COUNT(DEB_COUNT)) u_finish (
        .Clock (Clock),
        .Reset (Reset),
        .key_n (KeyFinish_n),
        .press (finish_ev)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sw_sync1 <= 4'd0;
            sw_sync2 <= 4'd0;
            state    <= IDLE;
            Digit    <= 4'd0;
            Count    <= 3'd0;
            Valid    <= 1'b0;
            Finish   <= 1'b0;
            Invalid  <= 1'b0;
        end else begin
            sw_sync1 <= SwDigit;
            sw_sync2 <= sw_sync1;
            state    <= state_next;
            Digit    <= digit_next;
            Count    <= count_next;
            Valid    <= valid_next;
            Finish   <= finish_next;
            Invalid  <= invalid_next;
        end
    end

    // Finish outranks confirm; a locked vote silently ignores further confirms.
    always_comb begin
        state_next   = state;
        digit_next   = Digit;
        count_next   = Count;
        valid_next   = 1'b0;
        finish_next  = 1'b0;
        invalid_next = 1'b0;
        if (finish_ev) begin
            finish_next = 1'b1;
            count_next  = 3'd0;
            state_next  = IDLE;
        end else if (confirm_ev && state != LOCKED) begin
            if (sw_sync2 > 4'd9) begin
                invalid_next = 1'b1;
            end else begin
                valid_next = 1'b1;
                digit_next = sw_sync2;
                count_next = Count + 3'd1;
                state_next = (Count == 3'd3) ? LOCKED : COLLECT;
            end
        end
    end

    assign Locked = (state == LOCKED);

endmodule

// File: tb/tb_urna_entrada.sv
// tb/tb_urna_entrada.sv - scoreboard bench for urna_entrada with DEB_COUNT=4
// Expected output events are queued at stimulus time and matched as pulses appear.

module tb_urna_entrada;

    localparam int DEB = 4;
    localparam int K_VALID = 0;
    localparam int K_INVALID = 1;
    localparam int K_FINISH = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] SwDigit = 4'd0;
    logic       KeyConfirm_n = 1'b1;
    logic       KeyFinish_n = 1'b1;
    logic [3:0] Digit;
    logic       Valid;
    logic       Finish;
    logic [2:0] Count;
    logic       Locked;
    logic       Invalid;

    urna_entrada #(.DEB_COUNT(DEB)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .SwDigit      (SwDigit),
        .KeyConfirm_n (KeyConfirm_n),
        .KeyFinish_n  (KeyFinish_n),
        .Digit        (Digit),
        .Valid        (Valid),
        .Finish       (Finish),
        .Count        (Count),
        .Locked       (Locked),
        .Invalid      (Invalid)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [3:0] digit;
        logic [2:0] count;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic pv = 1'b0, pf = 1'b0, pi = 1'b0;
    int   mon_kind;
    exp_t mon_e;

    // Every cycle of the run passes through here, so output pulses are never missed.
    task automatic step();
        @(negedge Clock);
        if (Valid || Invalid || Finish) begin
            mon_kind = Valid ? K_VALID : (Invalid ? K_INVALID : K_FINISH);
            checks++;
            if (int'(Valid) + int'(Invalid) + int'(Finish) > 1) begin
                errors++;
                $display("FAIL pulse_overlap: got valid=%0b invalid=%0b finish=%0b, expected at most one", Valid, Invalid, Finish);
            end
            checks++;
            if ((Valid && pv) || (Finish && pf) || (Invalid && pi)) begin
                errors++;
                $display("FAIL pulse_width: pulse kind %0d high two cycles at cycle %0d, expected one", mon_kind, cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got kind %0d digit %0d at cycle %0d, expected none", mon_kind, Digit, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_kind !== mon_e.kind || Digit !== mon_e.digit || Count !== mon_e.count ||
                    (mon_e.at != 0 && cyc != mon_e.at)) begin
                    errors++;
                    $display("FAIL event: got kind %0d digit %0d count %0d cycle %0d, expected kind %0d digit %0d count %0d cycle %0d",
                             mon_kind, Digit, Count, cyc, mon_e.kind, mon_e.digit, mon_e.count, mon_e.at);
                end
            end
        end
        pv = Valid;
        pf = Finish;
        pi = Invalid;
    endtask

    task automatic tick(input int n);
        repeat (n) step();
    endtask

    task automatic push_exp(input int kind, input logic [3:0] d, input logic [2:0] c, input int at);
        exp_t e;
        e.kind  = kind;
        e.digit = d;
        e.count = c;
        e.at    = at;
        sb.push_back(e);
    endtask

    // Clean press of confirm and/or finish; the pulse is due DEB+3 edges after the drive.
    task automatic press(input bit conf, input bit fin, input logic [3:0] d, input bit exp_ev,
                         input int kind, input logic [3:0] ed, input logic [2:0] ec);
        step();
        SwDigit = d;
        if (conf) KeyConfirm_n = 1'b0;
        if (fin) KeyFinish_n = 1'b0;
        if (exp_ev) push_exp(kind, ed, ec, cyc + DEB + 3);
        tick(DEB + 6);
        KeyConfirm_n = 1'b1;
        KeyFinish_n  = 1'b1;
        tick(DEB + 6);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d events still pending after %0d cycles, expected 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(3);
        checks += 6;
        if (Digit !== 4'd0)  begin errors++; $display("FAIL reset_digit: got %0d expected 0", Digit); end
        if (Valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %0b expected 0", Valid); end
        if (Finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %0b expected 0", Finish); end
        if (Invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid: got %0b expected 0", Invalid); end
        if (Count !== 3'd0)  begin errors++; $display("FAIL reset_count: got %0d expected 0", Count); end
        if (Locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", Locked); end
        Reset = 1'b0;
        tick(4);
    endtask

    task automatic test_single_digit();
        press(1, 0, 4'd3, 1, K_VALID, 4'd3, 3'd1);
        wait_drain(20);
        checks += 2;
        if (Count !== 3'd1)  begin errors++; $display("FAIL single_count: got %0d expected 1", Count); end
        if (Locked !== 1'b0) begin errors++; $display("FAIL single_locked: got %0b expected 0", Locked); end
    endtask

    task automatic test_fill_lock();
        press(1, 0, 4'd4, 1, K_VALID, 4'd4, 3'd2);
        press(1, 0, 4'd9, 1, K_VALID, 4'd9, 3'd3);
        press(1, 0, 4'd4, 1, K_VALID, 4'd4, 3'd4);
        wait_drain(20);
        checks += 2;
        if (Count !== 3'd4)  begin errors++; $display("FAIL lock_count: got %0d expected 4", Count); end
        if (Locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %0b expected 1", Locked); end
        press(1, 0, 4'd7, 0, 0, 4'd0, 3'd0);
        checks += 3;
        if (Count !== 3'd4)  begin errors++; $display("FAIL fifth_count: got %0d expected 4", Count); end
        if (Digit !== 4'd4)  begin errors++; $display("FAIL fifth_digit: got %0d expected 4", Digit); end
        if (Locked !== 1'b1) begin errors++; $display("FAIL fifth_locked: got %0b expected 1", Locked); end
        press(0, 1, 4'd0, 1, K_FINISH, 4'd4, 3'd0);
        wait_drain(20);
        checks += 3;
        if (Count !== 3'd0)  begin errors++; $display("FAIL finish_count: got %0d expected 0", Count); end
        if (Locked !== 1'b0) begin errors++; $display("FAIL finish_locked: got %0b expected 0", Locked); end
        if (Digit !== 4'd4)  begin errors++; $display("FAIL finish_digit: got %0d expected 4", Digit); end
    endtask

    task automatic test_bounce();
        step();
        SwDigit = 4'd5;
        KeyConfirm_n = 1'b0;
        tick(2);
        KeyConfirm_n = 1'b1;
        tick(2);
        KeyConfirm_n = 1'b0;
        push_exp(K_VALID, 4'd5, 3'd1, cyc + DEB + 3);
        tick(DEB + 8);
        KeyConfirm_n = 1'b1;
        tick(DEB + 8);
        wait_drain(20);
        checks++;
        if (Count !== 3'd1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", Count); end
    endtask

    task automatic test_invalid();
        press(1, 0, 4'd12, 1, K_INVALID, 4'd5, 3'd1);
        wait_drain(20);
        checks += 2;
        if (Count !== 3'd1) begin errors++; $display("FAIL invalid_count: got %0d expected 1", Count); end
        if (Digit !== 4'd5) begin errors++; $display("FAIL invalid_digit: got %0d expected 5", Digit); end
    endtask

    task automatic test_simultaneous();
        press(1, 0, 4'd8, 1, K_VALID, 4'd8, 3'd2);
        wait_drain(20);
        checks++;
        if (Count !== 3'd2) begin errors++; $display("FAIL simul_pre_count: got %0d expected 2", Count); end
        press(1, 1, 4'd6, 1, K_FINISH, 4'd8, 3'd0);
        wait_drain(20);
        checks += 2;
        if (Count !== 3'd0)  begin errors++; $display("FAIL simul_count: got %0d expected 0", Count); end
        if (Locked !== 1'b0) begin errors++; $display("FAIL simul_locked: got %0b expected 0", Locked); end
    endtask

    task automatic test_reset_during_press();
        step();
        SwDigit = 4'd2;
        KeyConfirm_n = 1'b0;
        tick(4);
        Reset = 1'b1;
        tick(3);
        Reset = 1'b0;
        tick(3 * DEB + 10);
        checks += 2;
        if (Count !== 3'd0) begin errors++; $display("FAIL held_count: got %0d expected 0", Count); end
        if (Digit !== 4'd0) begin errors++; $display("FAIL held_digit: got %0d expected 0", Digit); end
        KeyConfirm_n = 1'b1;
        tick(DEB + 8);
        press(1, 0, 4'd2, 1, K_VALID, 4'd2, 3'd1);
        wait_drain(20);
        checks += 2;
        if (Count !== 3'd1) begin errors++; $display("FAIL repress_count: got %0d expected 1", Count); end
        if (Digit !== 4'd2) begin errors++; $display("FAIL repress_digit: got %0d expected 2", Digit); end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_fill_lock();
        test_bounce();
        test_invalid();
        test_simultaneous();
        test_reset_during_press();
        tick(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending events, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
